pipe_adder: RTL and testbench
=============================

// Module: pipe_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit Adder.
//  Splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per pipeline stage.
//  Uses a valid/ready handshake so it can sit in the pipelined datapath
//  (PC/branch-target and EX-stage arithmetic) at higher clock rates.
//  Adds subtract mode plus carry, signed-overflow and zero flags.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be divisible by STAGES
//  STAGES  2   pipeline depth = number of chunks; 1..8; chunk width CW = WIDTH/STAGES
// PORTS
//  clk_i    in   1      clock; all state updates on the rising edge
//  rst_i    in   1      synchronous reset, active-high
//  valid_i  in   1      input operation valid
//  ready_o  out  1      unit accepts input this cycle
//  src1_i   in   WIDTH  operand A
//  src2_i   in   WIDTH  operand B
//  sub_i    in   1      0: A+B; 1: A-B (A + ~B + 1)
//  valid_o  out  1      result valid
//  ready_i  in   1      downstream accepts result
//  sum_o    out  WIDTH  result
//  carry_o  out  1      carry-out of MSB (for sub: 1 = no borrow)
//  ovf_o    out  1      signed two's-complement overflow
//  zero_o   out  1      sum_o == 0
// BEHAVIOUR
//  - Reset: every per-stage valid bit = 0; valid_o=0, sum_o=0, carry_o=0, ovf_o=0, zero_o=0.
//    ready_o=1 in the first cycle after reset is released.
//  - Reset mid-operation: all in-flight operations are discarded and never emitted.
//  - Global stall: adv = ready_i | ~valid_o; ready_o = adv (combinational).
//  - Input is accepted when valid_i & ready_o. When adv=0, all stage registers hold,
//    including data, valids and flags.
//  - Stage k (0..STAGES-1) adds chunk k of A and B', where B' = sub ? ~B : B.
//    Carry-in to stage 0 = sub_i; carry-in to stage k = the registered carry from stage k-1.
//    Upper operand chunks are delayed (skewed) and lower result chunks are delayed (deskewed).
//  - Latency: exactly STAGES cycles from acceptance to valid_o, with no stalls in between.
//    Throughput is 1 op/cycle. Results leave in acceptance order.
//  - valid_o/sum_o/flags stay stable while valid_o & ~ready_i; bubbles propagate as valid=0.
//  - Flags are computed in the final stage:
//    - carry_o = carry-out of bit WIDTH-1
//    - ovf_o = carry into MSB XOR carry out of MSB
//    - zero_o = ~|sum_o (evaluated after saturation, if enabled)
//  - When valid_o=0, the output data and flags hold their last values; they carry no meaning.
//  - STAGES=1 degenerates to a single registered adder (latency 1).
// CONFIGURATION
//  PIPE_ADDER_SAT_EN defined:
//    - On ovf, sum_o clamps: 0x7F..F if A is non-negative, 0x80..0 if A is negative
//      (A's sign is taken through the skew pipeline).
//    - ovf_o is still reported. carry_o is unchanged.
//  Not defined: sum_o wraps modulo 2^WIDTH. No clamp logic is instantiated.
// STRUCTURE
//  - Package adder_pkg:
//    - localparam MAX_STAGES=8
//    - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} add_op_e
//    - typedef struct {carry, ovf, zero} add_flags_t
//  - Sub-module adder_chunk: parametrised CW-bit registered adder slice with cin/cout and hold enable.
//    Instantiate it STAGES times in a generate loop.
//  - Skew/deskew shift registers, valid chain and SAT clamp live in pipe_adder.
// TESTING (WIDTH=32, STAGES=2 unless noted)
//  1. rst_i=1 for 2 cycles, then release -> valid_o=0, sum_o=0, all flags 0, ready_o=1.
//  2. 0x0000FFFF+0x00000001, sub=0 -> 2 cycles later: sum_o=0x00010000, carry 0, ovf 0, zero 0
//     (cross-chunk carry).
//  3. 0x7FFFFFFF+0x00000001 -> ovf_o=1. sum_o=0x80000000 without SAT_EN;
//     sum_o=0x7FFFFFFF with PIPE_ADDER_SAT_EN.
//  4. 5-5, sub=1 -> sum_o=0, zero_o=1, carry_o=1. Then 3-5 -> sum_o=0xFFFFFFFE, carry_o=0.
//  5. 4 back-to-back ops; ready_i=0 for 3 cycles after the first result appears ->
//     ready_o=0 during the stall, outputs held, all 4 results emitted in order with none lost.
//  6. 2 ops in flight, pulse rst_i for 1 cycle -> next cycle valid_o=0. Neither result ever emitted.
//     Repeat tests 2-5 with STAGES=1 and STAGES=4.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_pkg: shared types and limits for the pipelined add/sub unit.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adder_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } add_flags_t;

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_chunk: CW-bit registered adder slice with carry in/out, chunk  |
// | zero detect and hold enable.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adder_chunk #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o,
  output logic          zero_o
);

  logic [CW:0]   full_d;
  logic [CW-1:0] sum_q;
  logic          cout_q;
  logic          zero_q;

  assign full_d = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (en_i) begin
      sum_q  <= full_d[CW-1:0];
      cout_q <= full_d[CW];
      zero_q <= ~|full_d[CW-1:0];
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign zero_o = zero_q;

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_adder: STAGES-deep carry-chained add/sub with valid/ready and   |
// | carry/overflow/zero flags. Define PIPE_ADDER_SAT_EN to saturate.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int CW = WIDTH / STAGES;

  logic              adv;
  logic [STAGES:0]   vld_in;
  logic [STAGES-1:0] vld_q, vld_d, ld;
  logic [STAGES-1:0] cin_c, cout_c, zero_c;
  logic [CW-1:0]     a_c    [STAGES];
  logic [CW-1:0]     b_c    [STAGES];
  logic [CW-1:0]     sum_c  [STAGES];
  logic [WIDTH-1:0]  a_sk_q [STAGES];
  logic [WIDTH-1:0]  b_sk_q [STAGES];
  logic [WIDTH-1:0]  lo_q   [STAGES];
  logic [STAGES-1:0] zlo_q;
  logic              a_msb_q, b_msb_q;
  logic [WIDTH-1:0]  opb, sum_raw;
  logic              ovf, zero_all;
  add_op_e           op;
  add_flags_t        flags;

  assign op      = add_op_e'(sub_i);
  assign opb     = (op == OP_SUB) ? ~src2_i : src2_i;
  assign vld_in  = {vld_q, valid_i};
  assign valid_o = vld_in[STAGES];
  assign adv     = ready_i | ~valid_o;
  assign ready_o = adv;
  assign ld      = vld_in[STAGES-1:0] & {STAGES{adv}};
  assign vld_d   = adv ? vld_in[STAGES-1:0] : vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Slot k of the skew registers carries the operand bits still owed to stage k
  // (shifted down so they start at bit 0); slot k of lo_q collects the finished
  // lower chunks travelling alongside stage k. zlo_q[0] is a constant-one seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        a_sk_q[k] <= '0;
        b_sk_q[k] <= '0;
        lo_q[k]   <= '0;
      end
      zlo_q   <= STAGES'(1);
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k-1]) begin
          a_sk_q[k] <= ((k == 1) ? src1_i : a_sk_q[k-1]) >> CW;
          b_sk_q[k] <= ((k == 1) ? opb    : b_sk_q[k-1]) >> CW;
        end
        if (ld[k]) begin
          lo_q[k]  <= lo_q[k-1] | (WIDTH'(sum_c[k-1]) << ((k - 1) * CW));
          zlo_q[k] <= zlo_q[k-1] & zero_c[k-1];
        end
      end
      if (ld[STAGES-1]) begin
        a_msb_q <= a_c[STAGES-1][CW-1];
        b_msb_q <= b_c[STAGES-1][CW-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_c[k]   = src1_i[CW-1:0];
      assign b_c[k]   = opb[CW-1:0];
      assign cin_c[k] = sub_i;
    end else begin : g_tail
      assign a_c[k]   = a_sk_q[k][CW-1:0];
      assign b_c[k]   = b_sk_q[k][CW-1:0];
      assign cin_c[k] = cout_c[k-1];
    end

    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (ld[k]),
      .a_i    (a_c[k]),
      .b_i    (b_c[k]),
      .cin_i  (cin_c[k]),
      .sum_o  (sum_c[k]),
      .cout_o (cout_c[k]),
      .zero_o (zero_c[k])
    );
  end

  assign sum_raw  = lo_q[STAGES-1] | (WIDTH'(sum_c[STAGES-1]) << ((STAGES - 1) * CW));
  assign zero_all = zlo_q[STAGES-1] & zero_c[STAGES-1];
  // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
  assign ovf      = a_msb_q ^ b_msb_q ^ sum_c[STAGES-1][CW-1] ^ cout_c[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
  assign sum_o = ovf ? (a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                     : sum_raw;
  assign flags = '{carry: cout_c[STAGES-1], ovf: ovf, zero: zero_all & ~ovf};
`else
  assign sum_o = sum_raw;
  assign flags = '{carry: cout_c[STAGES-1], ovf: ovf, zero: zero_all};
`endif

  assign carry_o = flags.carry;
  assign ovf_o   = flags.ovf;
  assign zero_o  = flags.zero;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_adder: directed and random stimulus against a queue-based    |
// | arithmetic reference model of pipe_adder.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_adder;

  localparam int WIDTH = 32;
  parameter int STAGES = 2;

  logic             clk_i = 1'b0;
  logic             rst_i, valid_i, ready_o, sub_i, valid_o, ready_i;
  logic             carry_o, ovf_o, zero_o;
  logic [WIDTH-1:0] src1_i, src2_i, sum_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;
    int               age;
  } item_t;

  item_t q[$];

  always #5 clk_i = ~clk_i;

  pipe_adder #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .src1_i (src1_i),
    .src2_i (src2_i),
    .sub_i  (sub_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .sum_o  (sum_o),
    .carry_o(carry_o),
    .ovf_o  (ovf_o),
    .zero_o (zero_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from signed/unsigned integer arithmetic.
  function automatic item_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s);
    item_t  it;
    longint sa, sb, r, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = s ? sa - sb : sa + sb;
    lim = longint'(1) << (WIDTH - 1);
    it.ovf   = (r >= lim) || (r < -lim);
    it.carry = s ? (a >= b) : (((longint'(a) + longint'(b)) >> WIDTH) != 0);
    it.sum   = s ? a - b : a + b;
`ifdef PIPE_ADDER_SAT_EN
    if (it.ovf) it.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    it.zero = (it.sum == '0);
    it.age  = 1;
    return it;
  endfunction

  // One clock cycle: drive at the falling edge, check shortly after, then
  // advance the model to the state it will have after the next rising edge.
  task automatic step(input logic vi, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic rdy, input logic rst, output logic acc);
    logic exp_valid, exp_ready;
    rst_i   = rst;
    valid_i = vi;
    src1_i  = a;
    src2_i  = b;
    sub_i   = s;
    ready_i = rdy;
    #1;
    acc       = 1'b0;
    exp_valid = (q.size() > 0) && (q[0].age == STAGES);
    exp_ready = rdy | ~exp_valid;
    if (!rst) begin
      check_eq("valid_o", valid_o, exp_valid);
      check_eq("ready_o", ready_o, exp_ready);
      if (exp_valid) begin
        check_eq("sum_o", sum_o, q[0].sum);
        check_eq("carry_o", carry_o, q[0].carry);
        check_eq("ovf_o", ovf_o, q[0].ovf);
        check_eq("zero_o", zero_o, q[0].zero);
      end
    end
    if (rst) begin
      q.delete();
    end else if (exp_ready) begin
      if (exp_valid) begin
        void'(q.pop_front());
        n_pop++;
      end
      foreach (q[i]) q[i].age++;
      if (vi) begin
        q.push_back(model(a, b, s));
        acc = 1'b1;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    logic acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, a, b, s, 1'b1, 1'b0, acc);
    check_eq("issue_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    logic             acc;
    logic [WIDTH-1:0] a4 [4];
    logic [WIDTH-1:0] b4 [4];
    logic             s4 [4];
    int               nxt, pop0;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    src1_i = '0; src2_i = '0; sub_i = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);

    rst_i = 1'b0;
    #1;
    check_eq("rst_valid_o", valid_o, 1'b0);
    check_eq("rst_ready_o", ready_o, 1'b1);
    check_eq("rst_sum_o", sum_o, '0);
    check_eq("rst_carry_o", carry_o, 1'b0);
    check_eq("rst_ovf_o", ovf_o, 1'b0);
    check_eq("rst_zero_o", zero_o, 1'b0);
    @(negedge clk_i);

    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    idle(STAGES + 1);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    idle(STAGES + 1);
    issue(32'd5, 32'd5, 1'b1);
    issue(32'd3, 32'd5, 1'b1);
    idle(STAGES + 1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1);
    idle(STAGES + 1);

    a4[0] = 32'h1234_5678; b4[0] = 32'h0FED_CBA9; s4[0] = 1'b0;
    a4[1] = 32'h0001_0000; b4[1] = 32'h0000_0001; s4[1] = 1'b1;
    a4[2] = 32'hDEAD_BEEF; b4[2] = 32'h2152_4111; s4[2] = 1'b0;
    a4[3] = 32'h0000_0000; b4[3] = 32'h0000_0001; s4[3] = 1'b1;
    nxt  = 0;
    pop0 = n_pop;
    for (int cyc = 0; cyc < STAGES + 14; cyc++) begin
      logic rdy;
      rdy = !(cyc >= STAGES && cyc < STAGES + 3);
      if (nxt < 4) begin
        step(1'b1, a4[nxt], b4[nxt], s4[nxt], rdy, 1'b0, acc);
        if (acc) nxt++;
      end else begin
        step(1'b0, '0, '0, 1'b0, rdy, 1'b0, acc);
      end
    end
    check_eq("stall_issued", nxt, 4);
    check_eq("stall_emitted", n_pop - pop0, 4);

    issue(32'h0000_0011, 32'h0000_0022, 1'b0);
    issue(32'h0000_0033, 32'h0000_0044, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    idle(STAGES + 3);
    check_eq("flush_empty", q.size(), 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    idle(STAGES + 3);
    check_eq("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
